logic_gate_checker: RTL



---
 rtl/logic_gate_pkg.sv | 25 ++
 rtl/logic_gate_checker_gate_model.sv | 31 +++
 rtl/logic_gate_checker.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate checker and its golden model.
//   - OP_* codes select the golden function (NOT, AND, OR, NAND, NOR, XOR,
//     XNOR, BUF).
//   - ST_* constants are the checker FSM encoding (3-bit).
//   - MAX_N_IN is the largest supported gate input count.
package logic_gate_pkg;

  localparam int OP_NOT  = 0;
  localparam int OP_AND  = 1;
  localparam int OP_OR   = 2;
  localparam int OP_NAND = 3;
  localparam int OP_NOR  = 4;
  localparam int OP_XOR  = 5;
  localparam int OP_XNOR = 6;
  localparam int OP_BUF  = 7;

  localparam int MAX_N_IN = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_APPLY = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

endpackage

// File: rtl/logic_gate_checker_gate_model.sv
// gate_model: purely combinational golden reference for a single-output gate.
// Parameters:
//   OP   - function code (see logic_gate_pkg OP_*)
//   N_IN - input count, 1..MAX_N_IN (N_IN=1 only meaningful for NOT/BUF)
// Ports:
//   in - gate input vector
//   y  - expected gate output
module gate_model
  import logic_gate_pkg::*;
#(
  parameter int OP   = OP_NOT,
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] in,
  output logic            y
);

  always_comb begin
    case (OP)
      OP_NOT:  y = ~in[0];
      OP_AND:  y = &in;
      OP_OR:   y = |in;
      OP_NAND: y = ~&in;
      OP_NOR:  y = ~|in;
      OP_XOR:  y = ^in;
      OP_XNOR: y = ~^in;
      default: y = in[0];   // OP_BUF
    endcase
  end

endmodule

// File: rtl/logic_gate_checker.sv
// logic_gate_checker: sweeps every input combination onto a gate under test,
// waits SETTLE cycles per vector, samples the gate output and compares it
// with gate_model. Counts mismatches and records the first failing vector.
//
// Optional build macro: LOGIC_GATE_CHECK_STOP_ON_FAIL_EN
//   defined   - the first mismatch ends the sweep immediately (err_count=1)
//   undefined - the full sweep always runs and err_count totals mismatches
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset (aborts a sweep, no done)
//   start      - one-cycle pulse, accepted only in IDLE
//   stim       - registered vector driven to the gate inputs
//   resp       - gate output under test (synchronous to clk)
//   busy       - high from the cycle after an accepted start until done
//   done       - one-cycle pulse at the end of a sweep
//   pass       - 1 iff err_count==0, valid after done, cleared on start
//   err_count  - mismatches in the last sweep, saturates at 2^N_IN
//   fail_valid - a mismatch has been recorded in the current sweep
//   fail_vec   - stim value of the first mismatch
//   state_dbg  - current FSM state (ST_* encoding) for observation
//
// Handshake: start has no ready; it is taken only when the FSM is IDLE.
// A start seen while busy or during the done cycle is dropped, never queued.
module logic_gate_checker
  import logic_gate_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int OP     = OP_NOT,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec,
  output logic [2:0]      state_dbg
);

  localparam logic [N_IN-1:0] V_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_MAX = {1'b1, {N_IN{1'b0}}};
  // WAIT holds SETTLE-1 cycles; with SETTLE==1 it is skipped entirely.
  localparam logic [3:0]      WAIT_LAST = (SETTLE >= 2) ? 4'(SETTLE - 2) : 4'd0;

  logic [2:0]      state_q, state_d;
  logic [N_IN-1:0] v_q, v_d;
  logic [3:0]      wait_q, wait_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] fvec_q, fvec_d;

  logic model_y;
  logic mismatch;

  gate_model #(
    .OP   (OP),
    .N_IN (N_IN)
  ) u_model (
    .in (stim_q),
    .y  (model_y)
  );

  // Case inequality so that an X on resp is scored as a mismatch.
  assign mismatch = (resp !== model_y);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    wait_d  = wait_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
          v_d     = '0;
        end
      end

      ST_APPLY: begin
        stim_d  = v_q;
        wait_d  = '0;
        state_d = (SETTLE == 1) ? ST_CHECK : ST_WAIT;
      end

      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = stim_q;
          end
        end
`ifdef LOGIC_GATE_CHECK_STOP_ON_FAIL_EN
        if (mismatch || (v_q == V_LAST)) begin
          state_d = ST_FIN;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = ST_APPLY;
        end
`else
        if (v_q == V_LAST) begin
          state_d = ST_FIN;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = ST_APPLY;
        end
`endif
      end

      ST_FIN: begin
        // err_q already includes the final CHECK result here.
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        v_d     = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      wait_q  <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      wait_q  <= wait_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = (state_q == ST_FIN);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
  assign state_dbg  = state_q;

endmodule
